furv_bus_arbiter: RTL and testbench
===================================

// Module: furv_bus_arbiter
// PURPOSE
//  Shares one single-ported memory bus between two furv-style masters: M0 = instruction fetch, M1 = load/store.
//  Round-robin arbitration with per-transaction lock; one transaction in flight at a time.
//  Slave-ack watchdog returns an error-ack to the master so a dead slave cannot hang the core.
//  Sits between the core (plus its fetch unit) and the shared RAM/peripheral bus.
// PARAMETERS
//  ADDR_W   30  word-address width (byte lanes selected by sel)
//  DATA_W   32  data width; sel width = DATA_W/8
//  TIMEOUT  64  max cycles in BUSY awaiting s_ack before error-ack; 0 disables watchdog
// PORTS
//  clk        in   1       clock, all state on rising edge
//  rst_n      in   1       asynchronous, active-low reset
//  m0_req     in   1       M0 transaction request; held high until m0_ack
//  m0_we      in   1       M0 write enable
//  m0_addr    in   ADDR_W  M0 word address
//  m0_sel     in   DATA_W/8 M0 byte lane enables
//  m0_wdata   in   DATA_W  M0 write data
//  m0_rdata   out  DATA_W  read data (= s_rdata)
//  m0_ack     out  1       one-cycle completion strobe to M0
//  m0_err     out  1       with m0_ack: transaction timed out
//  m1_*       same set as m0_* for master M1
//  s_cyc      out  1       slave transaction active
//  s_we/s_addr/s_sel/s_wdata  out  granted master's fields
//  s_rdata    in   DATA_W  slave read data
//  s_ack      in   1       slave completion, sampled while s_cyc=1
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, grant=none, last=M1 (M0 wins first tie), wd_cnt=0;
//   s_cyc=0, s_we=0, s_addr=0, s_sel=0, s_wdata=0, m*_ack=0, m*_err=0. Reset mid-transaction aborts it silently, no ack.
//  States: IDLE, BUSY.
//  IDLE: if any req, register grant, latch that master's we/addr/sel/wdata into s_* regs, s_cyc<=1, -> BUSY.
//   Both req: grant the master != last. Single req: grant it. last<=granted.
//  BUSY: s_* outputs stable (registered). m*_rdata = s_rdata combinationally, both masters.
//   s_ack=1: m<g>_ack=1 same cycle (combinational from s_ack & state==BUSY & grant), s_cyc<=0, -> IDLE.
//   wd_cnt increments each BUSY cycle without ack; wd_cnt==TIMEOUT-1 and no s_ack: m<g>_ack=1, m<g>_err=1 one cycle, s_cyc<=0, -> IDLE.
//   s_ack on the expiry cycle wins: normal ack, err=0.
//   Granted master drops req before ack (protocol violation): abort, s_cyc<=0, -> IDLE, no ack.
//  Non-granted master never sees ack/err; its req is held pending.
//  Latency: req at edge N -> s_cyc=1 after edge N+1; zero-wait slave acks in that cycle -> 2 cycles req-to-ack.
//  Masters drop req on the cycle after ack; IDLE re-arbitrates the cycle after BUSY, so back-to-back alternation under contention.
//  wd_cnt width $clog2(TIMEOUT+1); cleared on entry to BUSY; never wraps (saturates only at expiry).
//  TIMEOUT=0: wd_cnt and err logic removed, m*_err tied 0.
// STRUCTURE
//  Package furv_bus_pkg: arb_state_t {IDLE,BUSY}; localparams MST_M0=0, MST_M1=1; sel-width function.
//  Sub-module furv_bus_watchdog: counter with clear/enable inputs, expire output, TIMEOUT param.
//  Top: arbitration FSM, registered slave mux, combinational ack/err/rdata routing.
// TESTING
//  1 M0 read addr 0x10, slave acks 1 cycle after s_cyc, s_rdata=0xDEADBEEF -> m0_rdata=0xDEADBEEF, m0_ack one cycle, m0_err=0.
//  2 M0,M1 req same edge after reset -> M0 first, M1 next; both held continuously -> grants alternate M0,M1,M0,M1.
//  3 M1 write addr 0x20 sel=4'b0011 wdata=0x1234 -> s_we=1, s_addr=0x20, s_sel=0011, s_wdata=0x1234 stable until s_ack.
//  4 TIMEOUT=64, slave never acks -> m1_ack=m1_err=1 exactly 64 BUSY cycles after grant; s_cyc=0 next cycle; s_ack on cycle 64 -> err=0.
//  5 rst_n low mid-BUSY -> s_cyc=0 and all acks 0 immediately (async); after release M0 wins tie.
//  6 Granted master drops req before ack -> s_cyc falls next edge, no m*_ack; pending other master then granted.

Source files
------------

// File: rtl/furv_bus_pkg.sv
// Shared types and helpers for the furv two-master bus arbiter.
// Used by the top-level arbiter and its watchdog sub-module.
package furv_bus_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  localparam logic MST_M0 = 1'b0;
  localparam logic MST_M1 = 1'b1;

  function automatic int sel_width(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/furv_bus_watchdog.sv
// Slave-ack watchdog: counts BUSY cycles and flags the last permitted cycle.
// With TIMEOUT=0 the counter is not built and expire_o is constant 0.
module furv_bus_watchdog #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam int CNT_W = $clog2(TIMEOUT + 1);
      localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT - 1);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      assign expire_o = (cnt_q == LAST_CNT);

      // Holding at the expiry value is harmless: the arbiter leaves BUSY on expiry.
      always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
          cnt_d = {CNT_W{1'b0}};
        end else if (en_i && !expire_o) begin
          cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          cnt_d = cnt_q;
        end
      end

      // Counter register.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_q <= {CNT_W{1'b0}};
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end else begin : g_no_wd
      assign expire_o = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/furv_bus_arbiter.sv
// Two-master round-robin arbiter (M0 fetch, M1 load/store) onto one memory bus,
// one transaction in flight, with a slave-ack watchdog returning an error-ack.
module furv_bus_arbiter
  import furv_bus_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           m0_req,
  input  logic                           m0_we,
  input  logic [ADDR_W-1:0]              m0_addr,
  input  logic [sel_width(DATA_W)-1:0]   m0_sel,
  input  logic [DATA_W-1:0]              m0_wdata,
  output logic [DATA_W-1:0]              m0_rdata,
  output logic                           m0_ack,
  output logic                           m0_err,
  input  logic                           m1_req,
  input  logic                           m1_we,
  input  logic [ADDR_W-1:0]              m1_addr,
  input  logic [sel_width(DATA_W)-1:0]   m1_sel,
  input  logic [DATA_W-1:0]              m1_wdata,
  output logic [DATA_W-1:0]              m1_rdata,
  output logic                           m1_ack,
  output logic                           m1_err,
  output logic                           s_cyc,
  output logic                           s_we,
  output logic [ADDR_W-1:0]              s_addr,
  output logic [sel_width(DATA_W)-1:0]   s_sel,
  output logic [DATA_W-1:0]              s_wdata,
  input  logic [DATA_W-1:0]              s_rdata,
  input  logic                           s_ack
);

  localparam int SEL_W = sel_width(DATA_W);

  arb_state_t        state_q, state_d;
  logic              grant_q, grant_d;
  logic              last_q, last_d;
  logic              s_cyc_q, s_cyc_d;
  logic              s_we_q, s_we_d;
  logic [ADDR_W-1:0] s_addr_q, s_addr_d;
  logic [SEL_W-1:0]  s_sel_q, s_sel_d;
  logic [DATA_W-1:0] s_wdata_q, s_wdata_d;

  logic busy_s;
  logic req_g_s;
  logic expire_s;
  logic ack_s;
  logic tmo_s;
  logic win_s;

  assign busy_s  = (state_q == BUSY);
  assign req_g_s = (grant_q == MST_M1) ? m1_req : m0_req;

  // A master that has dropped its request is not acked, even if the slave answers.
  assign ack_s = busy_s && req_g_s && s_ack;
  assign tmo_s = busy_s && req_g_s && !s_ack && expire_s;

  assign m0_ack   = (ack_s || tmo_s) && (grant_q == MST_M0);
  assign m1_ack   = (ack_s || tmo_s) && (grant_q == MST_M1);
  assign m0_err   = tmo_s && (grant_q == MST_M0);
  assign m1_err   = tmo_s && (grant_q == MST_M1);
  assign m0_rdata = s_rdata;
  assign m1_rdata = s_rdata;

  assign s_cyc   = s_cyc_q;
  assign s_we    = s_we_q;
  assign s_addr  = s_addr_q;
  assign s_sel   = s_sel_q;
  assign s_wdata = s_wdata_q;

  // On contention the master that did not win last time is chosen.
  always_comb begin
    if (m0_req && m1_req) begin
      win_s = (last_q == MST_M0) ? MST_M1 : MST_M0;
    end else if (m1_req) begin
      win_s = MST_M1;
    end else begin
      win_s = MST_M0;
    end
  end

  // Next-state, grant and slave-side register computation.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    s_cyc_d   = s_cyc_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_sel_d   = s_sel_q;
    s_wdata_d = s_wdata_q;
    case (state_q)
      IDLE: begin
        if (m0_req || m1_req) begin
          grant_d   = win_s;
          last_d    = win_s;
          s_cyc_d   = 1'b1;
          s_we_d    = (win_s == MST_M1) ? m1_we    : m0_we;
          s_addr_d  = (win_s == MST_M1) ? m1_addr  : m0_addr;
          s_sel_d   = (win_s == MST_M1) ? m1_sel   : m0_sel;
          s_wdata_d = (win_s == MST_M1) ? m1_wdata : m0_wdata;
          state_d   = BUSY;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (!req_g_s || ack_s || tmo_s) begin
          s_cyc_d = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = BUSY;
        end
      end
      default: begin
        s_cyc_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Arbiter FSM and registered slave-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= MST_M0;
      last_q    <= MST_M1;
      s_cyc_q   <= 1'b0;
      s_we_q    <= 1'b0;
      s_addr_q  <= {ADDR_W{1'b0}};
      s_sel_q   <= {SEL_W{1'b0}};
      s_wdata_q <= {DATA_W{1'b0}};
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      s_cyc_q   <= s_cyc_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_sel_q   <= s_sel_d;
      s_wdata_q <= s_wdata_d;
    end
  end

  furv_bus_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (!busy_s),
    .en_i     (busy_s),
    .expire_o (expire_s)
  );

endmodule

// File: tb/tb_furv_bus_arbiter.sv
// Directed bench for furv_bus_arbiter: a transaction-level model predicts the
// outputs every cycle, and literal checks pin the key scenarios.
module tb_furv_bus_arbiter;

  localparam int ADDR_W  = 30;
  localparam int DATA_W  = 32;
  localparam int SEL_W   = 4;
  localparam int TIMEOUT = 64;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              m0_req = 1'b0, m0_we = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic [SEL_W-1:0]  m0_sel = '0;
  logic [DATA_W-1:0] m0_wdata = '0;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_ack, m0_err;
  logic              m1_req = 1'b0, m1_we = 1'b0;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic [SEL_W-1:0]  m1_sel = '0;
  logic [DATA_W-1:0] m1_wdata = '0;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_ack, m1_err;
  logic              s_cyc, s_we;
  logic [ADDR_W-1:0] s_addr;
  logic [SEL_W-1:0]  s_sel;
  logic [DATA_W-1:0] s_wdata;
  logic [DATA_W-1:0] s_rdata = '0;
  logic              s_ack = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  furv_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_sel(m0_sel),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_sel(m1_sel),
    .m1_wdata(m1_wdata), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
    .s_cyc(s_cyc), .s_we(s_we), .s_addr(s_addr), .s_sel(s_sel), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: who owns the bus, which BUSY cycle it is, what was latched.
  logic              mdl_busy, mdl_g, mdl_last, mdl_we;
  int                mdl_bcnt;
  logic [ADDR_W-1:0] mdl_addr;
  logic [SEL_W-1:0]  mdl_sel;
  logic [DATA_W-1:0] mdl_wdata;

  function automatic logic pick(input logic r0, input logic r1, input logic last);
    if (r0 && r1) return ~last;
    return r1;
  endfunction

  function automatic logic req_of(input logic g);
    return g ? m1_req : m0_req;
  endfunction

  function automatic logic exp_ack(input logic g);
    return mdl_busy && (mdl_g == g) && req_of(g) && (s_ack || mdl_bcnt == TIMEOUT);
  endfunction

  function automatic logic exp_err(input logic g);
    return exp_ack(g) && !s_ack;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mdl_busy <= 1'b0; mdl_g <= 1'b0; mdl_last <= 1'b1; mdl_bcnt <= 0;
      mdl_we <= 1'b0; mdl_addr <= '0; mdl_sel <= '0; mdl_wdata <= '0;
    end else if (!mdl_busy) begin
      if (m0_req || m1_req) begin
        mdl_busy  <= 1'b1;
        mdl_g     <= pick(m0_req, m1_req, mdl_last);
        mdl_last  <= pick(m0_req, m1_req, mdl_last);
        mdl_bcnt  <= 1;
        mdl_we    <= pick(m0_req, m1_req, mdl_last) ? m1_we    : m0_we;
        mdl_addr  <= pick(m0_req, m1_req, mdl_last) ? m1_addr  : m0_addr;
        mdl_sel   <= pick(m0_req, m1_req, mdl_last) ? m1_sel   : m0_sel;
        mdl_wdata <= pick(m0_req, m1_req, mdl_last) ? m1_wdata : m0_wdata;
      end
    end else if (!req_of(mdl_g) || s_ack || mdl_bcnt == TIMEOUT) begin
      mdl_busy <= 1'b0;
    end else begin
      mdl_bcnt <= mdl_bcnt + 1;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("s_cyc", s_cyc, mdl_busy);
      chk("m0_ack", m0_ack, exp_ack(1'b0));
      chk("m1_ack", m1_ack, exp_ack(1'b1));
      chk("m0_err", m0_err, exp_err(1'b0));
      chk("m1_err", m1_err, exp_err(1'b1));
      chk("m0_rdata", m0_rdata, s_rdata);
      chk("m1_rdata", m1_rdata, s_rdata);
      if (mdl_busy) begin
        chk("s_we", s_we, mdl_we);
        chk("s_addr", s_addr, mdl_addr);
        chk("s_sel", s_sel, mdl_sel);
        chk("s_wdata", s_wdata, mdl_wdata);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m0_req = 1'b0; m1_req = 1'b0; s_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    int ord [4];
    int k;
    logic got;

    // Reset state
    #2;
    chk("rst_s_cyc", s_cyc, 1'b0);
    chk("rst_s_we", s_we, 1'b0);
    chk("rst_s_addr", s_addr, 30'h0);
    chk("rst_s_sel", s_sel, 4'h0);
    chk("rst_s_wdata", s_wdata, 32'h0);
    chk("rst_acks", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0000);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // 1: M0 read, slave acks in the first BUSY cycle
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 30'h10; m0_sel = 4'hF;
    step();
    chk("t1_s_cyc", s_cyc, 1'b1);
    chk("t1_s_addr", s_addr, 30'h10);
    s_ack = 1'b1; s_rdata = 32'hDEADBEEF;
    #1;
    chk("t1_m0_ack", m0_ack, 1'b1);
    chk("t1_m0_err", m0_err, 1'b0);
    chk("t1_m0_rdata", m0_rdata, 32'hDEADBEEF);
    chk("t1_m1_ack", m1_ack, 1'b0);
    step();
    s_ack = 1'b0; m0_req = 1'b0;
    chk("t1_ack_one_cycle", m0_ack, 1'b0);
    chk("t1_s_cyc_drop", s_cyc, 1'b0);
    step();

    // 2: contention right after reset -> M0,M1,M0,M1
    do_reset();
    m0_req = 1'b1; m1_req = 1'b1; m0_addr = 30'h100; m1_addr = 30'h200;
    step();
    for (int i = 0; i < 4; i++) begin
      s_ack = 1'b1;
      #1;
      ord[i] = m1_ack ? 1 : (m0_ack ? 0 : 9);
      step();
      s_ack = 1'b0;
      if (i == 3) begin
        m0_req = 1'b0; m1_req = 1'b0;
      end
      step();
    end
    chk("t2_grant0", ord[0], 0);
    chk("t2_grant1", ord[1], 1);
    chk("t2_grant2", ord[2], 0);
    chk("t2_grant3", ord[3], 1);

    // 3: M1 write, slave-side fields stable while waiting
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 30'h20; m1_sel = 4'b0011; m1_wdata = 32'h1234;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("t3_s_we", s_we, 1'b1);
      chk("t3_s_addr", s_addr, 30'h20);
      chk("t3_s_sel", s_sel, 4'b0011);
      chk("t3_s_wdata", s_wdata, 32'h1234);
      step();
    end
    s_ack = 1'b1;
    #1 chk("t3_m1_ack", m1_ack, 1'b1);
    step();
    s_ack = 1'b0; m1_req = 1'b0; m1_we = 1'b0;
    step();

    // 4a: dead slave -> error-ack on the 64th BUSY cycle
    m1_req = 1'b1; m1_addr = 30'h30;
    step();
    k = 1; got = 1'b0;
    while (k <= 200 && !got) begin
      #1;
      if (m1_ack) got = 1'b1;
      else begin
        step();
        k++;
      end
    end
    chk("t4_tmo_cycle", k, 64);
    chk("t4_m1_err", m1_err, 1'b1);
    step();
    m1_req = 1'b0;
    chk("t4_s_cyc_after", s_cyc, 1'b0);
    step();

    // 4b: ack arriving on the expiry cycle is a normal ack
    m1_req = 1'b1;
    step();
    repeat (63) step();
    s_ack = 1'b1;
    #1;
    chk("t4b_m1_ack", m1_ack, 1'b1);
    chk("t4b_m1_err", m1_err, 1'b0);
    step();
    s_ack = 1'b0; m1_req = 1'b0;
    step();

    // 5: async reset mid-BUSY, then M0 wins the first tie
    m0_req = 1'b1; m0_addr = 30'h44;
    step();
    step();
    #1;
    rst_n = 1'b0; s_ack = 1'b1;
    #1;
    chk("t5_s_cyc", s_cyc, 1'b0);
    chk("t5_acks", {m0_ack, m1_ack, m0_err, m1_err}, 4'b0000);
    chk("t5_s_addr", s_addr, 30'h0);
    s_ack = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1; m0_req = 1'b1; m1_req = 1'b1;
    step();
    s_ack = 1'b1;
    #1;
    chk("t5_tie_m0", {m0_ack, m1_ack}, 2'b10);
    step();
    s_ack = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
    step();

    // 6: granted master abandons its request; pending master then served
    m0_req = 1'b1; m0_addr = 30'h50;
    step();
    m1_req = 1'b1; m1_addr = 30'h60;
    step();
    m0_req = 1'b0;
    #1 chk("t6_no_ack", {m0_ack, m1_ack}, 2'b00);
    step();
    chk("t6_s_cyc_fall", s_cyc, 1'b0);
    step();
    chk("t6_m1_grant", s_cyc, 1'b1);
    chk("t6_m1_addr", s_addr, 30'h60);
    s_ack = 1'b1;
    #1 chk("t6_m1_ack", {m0_ack, m1_ack}, 2'b01);
    step();
    s_ack = 1'b0; m1_req = 1'b0;
    repeat (2) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
